// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects
// and the two-state mul/div sequencing machine.
package pipe_hazard_ctrl_pkg;

    localparam logic [1:0] FWD_RF   = 2'd0;
    localparam logic [1:0] FWD_EALU = 2'd1;
    localparam logic [1:0] FWD_MALU = 2'd2;
    localparam logic [1:0] FWD_MMEM = 2'd3;

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] MD_HOLD = 1'b1;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// Forwarding comparator (fwd_sel): picks the newest producer of one ID source
// register. EXE wins over MEM; register 0 is never forwarded.
module pipe_hazard_ctrl_fwd_sel
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [4:0] src,
    input  logic [4:0] ern,
    input  logic       ewreg,
    input  logic       em2reg,
    input  logic [4:0] mrn,
    input  logic       mwreg,
    input  logic       mm2reg,
    output logic [1:0] sel
);

    logic src_nz;

    assign src_nz = (src != 5'd0);

    always_comb begin
        sel = FWD_RF;
        // An EXE load has no data yet; that case is resolved by the load-use stall.
        if (ewreg && !em2reg && src_nz && (ern == src)) begin
            sel = FWD_EALU;
        end else if (mwreg && !mm2reg && src_nz && (mrn == src)) begin
            sel = FWD_MALU;
        end else if (mwreg && mm2reg && src_nz && (mrn == src)) begin
            sel = FWD_MMEM;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: operand forwarding, load-use
// stall, branch flush, fixed-latency mul/div hold in ID and a stall counter.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [4:0]       rs,
    input  logic [4:0]       rt,
    input  logic             usea,
    input  logic             useb,
    input  logic             dmd,
    input  logic             dtaken,
    input  logic [4:0]       ern,
    input  logic             ewreg,
    input  logic             em2reg,
    input  logic [4:0]       mrn,
    input  logic             mwreg,
    input  logic             mm2reg,
    output logic [1:0]       fwda,
    output logic [1:0]       fwdb,
    output logic             wpcir,
    output logic             dbubble,
    output logic             dflush,
    output logic             mdgo,
    output logic             mdbusy,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [3:0] HOLD_INIT = 4'(MD_LAT - 2);

    logic [0:0]       state_reg, state_next;
    logic [3:0]       hold_reg, hold_next;
    logic             mask_reg, mask_next;
    logic [CNT_W-1:0] stall_cnt_reg;
    logic             lu;
    logic             md_start;

    pipe_hazard_ctrl_fwd_sel u_fwd_a (
        .src    (rs),
        .ern    (ern),
        .ewreg  (ewreg),
        .em2reg (em2reg),
        .mrn    (mrn),
        .mwreg  (mwreg),
        .mm2reg (mm2reg),
        .sel    (fwda)
    );

    pipe_hazard_ctrl_fwd_sel u_fwd_b (
        .src    (rt),
        .ern    (ern),
        .ewreg  (ewreg),
        .em2reg (em2reg),
        .mrn    (mrn),
        .mwreg  (mwreg),
        .mm2reg (mm2reg),
        .sel    (fwdb)
    );

    assign lu = ewreg && em2reg && (ern != 5'd0) &&
                ((usea && (ern == rs)) || (useb && (ern == rt)));

    always_comb begin
        state_next = state_reg;
        hold_next  = hold_reg;
        mask_next  = 1'b0;
        wpcir      = 1'b1;
        dbubble    = 1'b0;
        dflush     = 1'b0;
        md_start   = 1'b0;
        if (state_reg == MD_HOLD) begin
            wpcir   = 1'b0;
            dbubble = 1'b1;
            if (hold_reg == 4'd0) begin
                state_next = IDLE;
                // The held mul/div is still in ID next cycle; stop it restarting.
                mask_next  = 1'b1;
            end else begin
                hold_next = hold_reg - 4'd1;
            end
        end else if (lu) begin
            wpcir   = 1'b0;
            dbubble = 1'b1;
        end else if (dmd && !mask_reg) begin
            md_start   = 1'b1;
            wpcir      = 1'b0;
            dbubble    = 1'b1;
            state_next = MD_HOLD;
            hold_next  = HOLD_INIT;
        end else begin
            dflush = dtaken;
        end
    end

    // Gated by clrn so the start pulse drops the moment reset is asserted.
    assign mdgo      = clrn && md_start;
    assign mdbusy    = (state_reg == MD_HOLD);
    assign stall_cnt = stall_cnt_reg;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_reg     <= IDLE;
            hold_reg      <= 4'd0;
            mask_reg      <= 1'b0;
            stall_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            hold_reg  <= hold_next;
            mask_reg  <= mask_next;
            if (!wpcir && (stall_cnt_reg != {CNT_W{1'b1}})) begin
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            end
        end
    end

endmodule
